// File: rtl/quad_tune_encoder_if.sv
// ---------------------------------------------------------------------------
// quad_tune_encoder_if
//
// Purpose:
//    Bundles the rotary-encoder pins and the frequency-change report that the
//    encoder front end hands to the MCU interrupt logic.
//
// Signals:
//    enc_a            encoder channel A, raw asynchronous pin
//    enc_b            encoder channel B, raw asynchronous pin
//    fq_change        signed 8-bit detent delta for the last report window
//    fq_change_valid  single-cycle strobe marking a new fq_change value
//
// Modports:
//    master  board / consumer side: drives the pins, receives the report
//    slave   the encoder block: samples the pins, drives the report
// ---------------------------------------------------------------------------
interface quad_tune_encoder_if;

   logic       enc_a;
   logic       enc_b;
   logic [7:0] fq_change;
   logic       fq_change_valid;

   modport master (
      output enc_a,
      output enc_b,
      input  fq_change,
      input  fq_change_valid
   );

   modport slave (
      input  enc_a,
      input  enc_b,
      output fq_change,
      output fq_change_valid
   );

endinterface

// File: rtl/quad_tune_encoder.sv
// ---------------------------------------------------------------------------
// quad_tune_encoder
//
// Purpose:
//    Front-panel tuning-control front end. Synchronizes and debounces the two
//    quadrature pins of a mechanical rotary encoder, decodes Gray-code
//    transitions into signed detents, accumulates detents over a fixed report
//    window and emits at most one saturated signed 8-bit delta per window.
//    This bounds the MCU frequency-change interrupt rate regardless of how
//    fast the encoder is spun.
//
// Ports:
//    aclk                       system clock, all state updates on its rising edge
//    reset                      synchronous, active-high reset
//    enc_if.enc_a / enc_b       raw encoder pins (asynchronous)
//    enc_if.fq_change           signed detent delta, held until the next strobe
//    enc_if.fq_change_valid     one-cycle strobe per non-empty report window
//
// Parameters:
//    DEBOUNCE_CYCLES    stable cycles needed before a pin change is accepted (>=1)
//    REPORT_CYCLES      report window length in aclk cycles (>=2)
//    COUNTS_PER_DETENT  valid Gray transitions per mechanical detent (1, 2, 4)
//    ACCEL_THRESHOLD    |detents| per window at which acceleration kicks in
//
// Optional build macro:
//    ENCODER_ACCEL_EN   when defined, windows with |accum| >= ACCEL_THRESHOLD
//                       report accum*4 saturated to +/-127; when undefined the
//                       accumulator is reported unchanged and no multiply
//                       logic exists.
// ---------------------------------------------------------------------------
module quad_tune_encoder #(
   parameter int DEBOUNCE_CYCLES   = 1000,
   parameter int REPORT_CYCLES     = 100000,
   parameter int COUNTS_PER_DETENT = 4,
   parameter int ACCEL_THRESHOLD   = 4
) (
   input  logic               aclk,
   input  logic               reset,
   quad_tune_encoder_if.slave enc_if
);

   typedef enum logic {
      ST_INIT,
      ST_RUN
   } state_t;

   // Counter widths. The debounce counter only ever holds 0..DEBOUNCE_CYCLES-1,
   // the INIT counter 0..DEBOUNCE_CYCLES+1 and the report timer 0..REPORT_CYCLES-1.
   localparam int DB_W   = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
   localparam int INIT_W = $clog2(DEBOUNCE_CYCLES + 2);
   localparam int TMR_W  = $clog2(REPORT_CYCLES);

   localparam logic [DB_W-1:0]   DB_LAST   = DB_W'(DEBOUNCE_CYCLES - 1);
   localparam logic [INIT_W-1:0] INIT_LAST = INIT_W'(DEBOUNCE_CYCLES + 1);
   localparam logic [TMR_W-1:0]  TMR_LAST  = TMR_W'(REPORT_CYCLES - 1);

   localparam logic signed [3:0] SUB_MAX = 4'(COUNTS_PER_DETENT);
   localparam logic signed [7:0] ACC_MAX = 8'sd127;
   localparam logic signed [7:0] ACC_MIN = -8'sd127;

   // Reject parameter values the datapath was not sized for.
   if (DEBOUNCE_CYCLES < 1 || REPORT_CYCLES < 2 ||
       !(COUNTS_PER_DETENT == 1 || COUNTS_PER_DETENT == 2 || COUNTS_PER_DETENT == 4) ||
       ACCEL_THRESHOLD < 1 || ACCEL_THRESHOLD > 127) begin : g_param_check
      $error("quad_tune_encoder: illegal parameter value");
   end

   // Pin pipeline; index 1 is channel A, index 0 is channel B so that the
   // debounced pair reads directly as {a,b}.
   logic [1:0]        pin_meta;
   logic [1:0]        pin_sync;
   logic [1:0]        pin_deb;
   logic [DB_W-1:0]   db_cnt [2];

   state_t            state_q;
   state_t            state_d;
   logic [INIT_W-1:0] init_cnt_q;
   logic [INIT_W-1:0] init_cnt_d;
   logic [1:0]        prev_ab_q;
   logic [1:0]        prev_ab_d;
   logic signed [3:0] sub_q;
   logic signed [3:0] sub_d;
   logic signed [7:0] accum_q;
   logic signed [7:0] accum_d;
   logic [TMR_W-1:0]  timer_q;
   logic [TMR_W-1:0]  timer_d;
   logic [7:0]        fq_change_q;
   logic [7:0]        fq_change_d;
   logic              valid_q;
   logic              valid_d;

   logic [1:0]        cur_ab;
   logic signed [3:0] gray_dir;
   logic signed [3:0] sub_sum;
   logic signed [3:0] sub_next;
   logic              step_up;
   logic              step_dn;
   logic signed [7:0] step_val;
   logic signed [7:0] accum_sat;
   logic signed [7:0] report_value;

   // Two-flop synchronizer per channel; the pins are asynchronous to aclk.
   always_ff @(posedge aclk) begin
      if (reset) begin
         pin_meta <= '0;
         pin_sync <= '0;
      end else begin
         pin_meta <= {enc_if.enc_a, enc_if.enc_b};
         pin_sync <= pin_meta;
      end
   end

   // Per-channel debounce: the counter only advances while the synchronized
   // pin disagrees with the accepted value, so any bounce back restarts the
   // wait. Accepting on the count of DEBOUNCE_CYCLES-1 makes the accepted
   // value follow the pin exactly 2+DEBOUNCE_CYCLES edges after it moves.
   always_ff @(posedge aclk) begin
      if (reset) begin
         pin_deb <= '0;
         for (int i = 0; i < 2; i++) begin
            db_cnt[i] <= '0;
         end
      end else begin
         for (int i = 0; i < 2; i++) begin
            if (pin_sync[i] == pin_deb[i]) begin
               db_cnt[i] <= '0;
            end else if (db_cnt[i] == DB_LAST) begin
               pin_deb[i] <= pin_sync[i];
               db_cnt[i]  <= '0;
            end else begin
               db_cnt[i] <= db_cnt[i] + DB_W'(1);
            end
         end
      end
   end

   assign cur_ab = pin_deb;

   // Gray decode of the debounced pair against the last seen pair. Clockwise
   // runs 00->01->11->10->00. No change and the illegal double-bit jump both
   // decode to zero, which leaves the sub-detent counter untouched.
   always_comb begin
      gray_dir = 4'sd0;
      case ({prev_ab_q, cur_ab})
         4'b00_01, 4'b01_11, 4'b11_10, 4'b10_00: gray_dir = 4'sd1;
         4'b00_10, 4'b10_11, 4'b11_01, 4'b01_00: gray_dir = -4'sd1;
         default:                                gray_dir = 4'sd0;
      endcase
   end

   // Sub-detent counter: a full detent in either direction emits one step and
   // returns to zero; a reversal part-way simply walks back toward zero.
   always_comb begin
      sub_sum  = sub_q + gray_dir;
      sub_next = sub_sum;
      step_up  = 1'b0;
      step_dn  = 1'b0;
      if (sub_sum == SUB_MAX) begin
         sub_next = 4'sd0;
         step_up  = 1'b1;
      end else if (sub_sum == -SUB_MAX) begin
         sub_next = 4'sd0;
         step_dn  = 1'b1;
      end
   end

   // Saturating accumulate. The range is kept symmetric at +/-127 so that a
   // reported value can always be negated by the MCU without overflow.
   always_comb begin
      step_val  = 8'sd0;
      accum_sat = accum_q;
      if (step_up) begin
         step_val = 8'sd1;
         if (accum_q != ACC_MAX) begin
            accum_sat = accum_q + 8'sd1;
         end
      end else if (step_dn) begin
         step_val = -8'sd1;
         if (accum_q != ACC_MIN) begin
            accum_sat = accum_q - 8'sd1;
         end
      end
   end

`ifdef ENCODER_ACCEL_EN
   logic signed [9:0] acc_wide;
   logic signed [9:0] acc_x4;
   logic signed [9:0] acc_mag;

   // Fast spins are scaled by four. Ten bits hold 127*4 = 508 without
   // overflow, so the clamp below sees the true product.
   always_comb begin
      acc_wide     = {{2{accum_q[7]}}, accum_q};
      acc_x4       = acc_wide <<< 2;
      acc_mag      = acc_wide[9] ? -acc_wide : acc_wide;
      report_value = accum_q;
      if (acc_mag >= signed'(10'(ACCEL_THRESHOLD))) begin
         if (acc_x4 > 10'sd127) begin
            report_value = ACC_MAX;
         end else if (acc_x4 < -10'sd127) begin
            report_value = ACC_MIN;
         end else begin
            report_value = acc_x4[7:0];
         end
      end
   end
`else
   assign report_value = accum_q;
`endif

   // Next-state logic. INIT gives the synchronizers and debouncers time to
   // settle on the encoder's resting position before it is adopted as prev_ab,
   // so an encoder parked mid-cycle at power-up is not counted as a move. In
   // RUN the terminal timer cycle publishes the window and reloads the
   // accumulator with this cycle's step, so a detent finishing exactly on the
   // boundary is carried into the next window instead of being lost.
   always_comb begin
      state_d     = state_q;
      init_cnt_d  = init_cnt_q;
      prev_ab_d   = prev_ab_q;
      sub_d       = sub_q;
      accum_d     = accum_q;
      timer_d     = timer_q;
      fq_change_d = fq_change_q;
      valid_d     = 1'b0;

      case (state_q)
         ST_INIT: begin
            if (init_cnt_q == INIT_LAST) begin
               state_d   = ST_RUN;
               prev_ab_d = cur_ab;
            end else begin
               init_cnt_d = init_cnt_q + INIT_W'(1);
            end
         end

         ST_RUN: begin
            prev_ab_d = cur_ab;
            sub_d     = sub_next;
            if (timer_q == TMR_LAST) begin
               timer_d = '0;
               accum_d = step_val;
               if (accum_q != 8'sd0) begin
                  fq_change_d = report_value;
                  valid_d     = 1'b1;
               end
            end else begin
               timer_d = timer_q + TMR_W'(1);
               accum_d = accum_sat;
            end
         end

         default: begin
            state_d = ST_INIT;
         end
      endcase
   end

   // State register for the FSM and all decode/report state.
   always_ff @(posedge aclk) begin
      if (reset) begin
         state_q     <= ST_INIT;
         init_cnt_q  <= '0;
         prev_ab_q   <= '0;
         sub_q       <= '0;
         accum_q     <= '0;
         timer_q     <= '0;
         fq_change_q <= '0;
         valid_q     <= 1'b0;
      end else begin
         state_q     <= state_d;
         init_cnt_q  <= init_cnt_d;
         prev_ab_q   <= prev_ab_d;
         sub_q       <= sub_d;
         accum_q     <= accum_d;
         timer_q     <= timer_d;
         fq_change_q <= fq_change_d;
         valid_q     <= valid_d;
      end
   end

   assign enc_if.fq_change       = fq_change_q;
   assign enc_if.fq_change_valid = valid_q;

endmodule

// File: tb/tb_quad_tune_encoder.sv
// ---------------------------------------------------------------------------
// tb_quad_tune_encoder
//
// Two encoder instances share clock and reset:
//    u_dut      DEBOUNCE_CYCLES=4, REPORT_CYCLES=200 : idle, CW, CCW, glitch,
//               boundary-carry and mid-window reset scenarios
//    u_dut_sat  same debounce, REPORT_CYCLES=8000  : long windows so that
//               hundreds of detents fit in one window (saturation and the
//               acceleration vectors)
//
// Timing reference: cyc counts rising edges since reset was released. The
// first report terminal count lands after edge DEBOUNCE+1+REPORT, so strobes
// are visible at the falling edge where cyc = 6 + REPORT*(n+1). A pin driven
// at the falling edge where cyc = d moves the step into the accumulator on
// edge d+6.
// ---------------------------------------------------------------------------
module tb_quad_tune_encoder;

   localparam int DEB     = 4;
   localparam int REP     = 200;
   localparam int REP_SAT = 8000;
   localparam int CPD     = 4;

`ifdef ENCODER_ACCEL_EN
   localparam logic [7:0] EXP_P5  = 8'h14;
   localparam logic [7:0] EXP_P40 = 8'h7F;
   localparam logic [7:0] EXP_M5  = 8'hEC;
`else
   localparam logic [7:0] EXP_P5  = 8'h05;
   localparam logic [7:0] EXP_P40 = 8'h28;
   localparam logic [7:0] EXP_M5  = 8'hFB;
`endif

   typedef struct {
      logic [7:0] value;
      int         cyc;
   } expect_t;

   logic    aclk  = 1'b0;
   logic    reset = 1'b1;
   int      cyc   = 0;
   int      tests_run    = 0;
   int      tests_failed = 0;
   expect_t main_q[$];
   expect_t sat_q[$];
   logic [1:0] main_ab = 2'b00;
   logic [1:0] sat_ab  = 2'b00;
   logic    main_prev_valid = 1'b0;
   logic    sat_prev_valid  = 1'b0;

   quad_tune_encoder_if main_if();
   quad_tune_encoder_if sat_if();

   quad_tune_encoder #(
      .DEBOUNCE_CYCLES   (DEB),
      .REPORT_CYCLES     (REP),
      .COUNTS_PER_DETENT (CPD),
      .ACCEL_THRESHOLD   (4)
   ) u_dut (
      .aclk   (aclk),
      .reset  (reset),
      .enc_if (main_if)
   );

   quad_tune_encoder #(
      .DEBOUNCE_CYCLES   (DEB),
      .REPORT_CYCLES     (REP_SAT),
      .COUNTS_PER_DETENT (CPD),
      .ACCEL_THRESHOLD   (4)
   ) u_dut_sat (
      .aclk   (aclk),
      .reset  (reset),
      .enc_if (sat_if)
   );

   always #5 aclk = ~aclk;

   always @(posedge aclk) begin
      if (reset) cyc <= 0;
      else       cyc <= cyc + 1;
   end

   task automatic checkOutput(input string name, input int actual, input int expected);
      tests_run++;
      if (actual !== expected) begin
         tests_failed++;
         $display("[TB] FAIL %s: got 0x%0h (%0d), required 0x%0h (%0d) at cycle %0d",
                  name, actual, actual, expected, expected, cyc);
      end
   endtask

   task automatic expectStrobe(input bit use_sat, input logic [7:0] value, input int at_cyc);
      expect_t e;
      e.value = value;
      e.cyc   = at_cyc;
      if (use_sat) sat_q.push_back(e);
      else         main_q.push_back(e);
   endtask

   task automatic waitCyc(input int target);
      int guard = 0;
      while (cyc < target) begin
         @(negedge aclk);
         guard++;
         if (guard > 60000) begin
            tests_failed++;
            $display("[TB] FAIL wait_timeout: cycle %0d never reached, stuck at %0d", target, cyc);
            $fatal(1, "[TB] wait bound expired");
         end
      end
   endtask

   // One Gray step on the chosen encoder: dir > 0 clockwise, otherwise counter-clockwise.
   task automatic applyStimulus(input bit use_sat, input int dir);
      logic [1:0] ab;
      ab = use_sat ? sat_ab : main_ab;
      if (dir > 0) begin
         case (ab)
            2'b00:   ab = 2'b01;
            2'b01:   ab = 2'b11;
            2'b11:   ab = 2'b10;
            default: ab = 2'b00;
         endcase
      end else begin
         case (ab)
            2'b00:   ab = 2'b10;
            2'b10:   ab = 2'b11;
            2'b11:   ab = 2'b01;
            default: ab = 2'b00;
         endcase
      end
      if (use_sat) begin
         sat_ab       = ab;
         sat_if.enc_a = ab[1];
         sat_if.enc_b = ab[0];
      end else begin
         main_ab       = ab;
         main_if.enc_a = ab[1];
         main_if.enc_b = ab[0];
      end
   endtask

   task automatic applySteps(input bit use_sat, input int dir, input int count,
                             input int start, input int spacing);
      for (int i = 0; i < count; i++) begin
         waitCyc(start + i * spacing);
         applyStimulus(use_sat, dir);
      end
   endtask

   // One-cycle reset pulse issued from a falling edge; outputs are checked
   // while reset is still high, right after the resetting edge.
   task automatic pulseReset(input string tag);
      reset = 1'b1;
      @(negedge aclk);
      checkOutput({tag, "_fq_change"}, main_if.fq_change, 0);
      checkOutput({tag, "_valid"}, main_if.fq_change_valid, 0);
      reset = 1'b0;
   endtask

   // Scoreboard monitor for the short-window instance.
   always @(negedge aclk) begin
      expect_t e;
      if (reset) begin
         main_prev_valid <= 1'b0;
      end else begin
         if (main_if.fq_change_valid) begin
            checkOutput("main_no_back_to_back", main_prev_valid, 0);
            if (main_q.size() == 0) begin
               tests_run++;
               tests_failed++;
               $display("[TB] FAIL main_unexpected_strobe: got fq_change=0x%0h at cycle %0d, required no strobe",
                        main_if.fq_change, cyc);
            end else begin
               e = main_q.pop_front();
               checkOutput("main_strobe_value", main_if.fq_change, e.value);
               checkOutput("main_strobe_cycle", cyc, e.cyc);
            end
         end
         main_prev_valid <= main_if.fq_change_valid;
      end
   end

   // Scoreboard monitor for the long-window instance.
   always @(negedge aclk) begin
      expect_t e;
      if (reset) begin
         sat_prev_valid <= 1'b0;
      end else begin
         if (sat_if.fq_change_valid) begin
            checkOutput("sat_no_back_to_back", sat_prev_valid, 0);
            if (sat_q.size() == 0) begin
               tests_run++;
               tests_failed++;
               $display("[TB] FAIL sat_unexpected_strobe: got fq_change=0x%0h at cycle %0d, required no strobe",
                        sat_if.fq_change, cyc);
            end else begin
               e = sat_q.pop_front();
               checkOutput("sat_strobe_value", sat_if.fq_change, e.value);
               checkOutput("sat_strobe_cycle", cyc, e.cyc);
            end
         end
         sat_prev_valid <= sat_if.fq_change_valid;
      end
   end

   initial begin
      main_if.enc_a = 1'b0;
      main_if.enc_b = 1'b0;
      sat_if.enc_a  = 1'b0;
      sat_if.enc_b  = 1'b0;
      reset = 1'b1;
      repeat (3) @(negedge aclk);

      // Reset state.
      checkOutput("reset_fq_change", main_if.fq_change, 0);
      checkOutput("reset_valid", main_if.fq_change_valid, 0);
      checkOutput("reset_sat_fq_change", sat_if.fq_change, 0);
      reset = 1'b0;

      // Test 1: static pins for three windows (strobe slots 206/406/606).
      waitCyc(610);
      checkOutput("t1_idle_fq_change", main_if.fq_change, 0);

      // Test 2: 3 CW detents in window 3, then an idle window 4.
      expectStrobe(1'b0, 8'h03, 806);
      applySteps(1'b0, 1, 12, 610, 10);
      waitCyc(1010);
      checkOutput("t2_hold_after_idle", main_if.fq_change, 8'h03);

      // Test 3: 2 CCW detents in window 5.
      expectStrobe(1'b0, 8'hFE, 1206);
      applySteps(1'b0, -1, 8, 1010, 10);

      // Test 4: 3-cycle glitch, CW/CCW wobble, then a detent whose last step
      // lands on window 6's terminal edge (1405) and so reports in window 7.
      waitCyc(1210);
      main_if.enc_a = 1'b1;
      waitCyc(1213);
      main_if.enc_a = 1'b0;
      applySteps(1'b0, 1, 2, 1230, 10);
      applySteps(1'b0, -1, 2, 1250, 10);
      applySteps(1'b0, 1, 3, 1370, 10);
      expectStrobe(1'b0, 8'h01, 1606);
      waitCyc(1399);
      applyStimulus(1'b0, 1);
      waitCyc(1410);
      checkOutput("t4_hold_no_strobe", main_if.fq_change, 8'hFE);
      waitCyc(1620);

      // Test 5, reset run: report 2 detents, then reset mid-window with a
      // detent still accumulated; it must be discarded and timing restart.
      pulseReset("t5_restart");
      expectStrobe(1'b0, 8'h02, 206);
      applySteps(1'b0, 1, 8, 20, 10);
      applySteps(1'b0, 1, 4, 220, 10);
      waitCyc(300);
      pulseReset("t5_mid_window");
      waitCyc(210);
      checkOutput("t5_no_stale_report", main_if.fq_change, 0);
      expectStrobe(1'b0, 8'h01, 406);
      applySteps(1'b0, 1, 4, 220, 10);
      waitCyc(420);

      // Test 5 saturation and test 6 acceleration on the long-window instance.
      pulseReset("t6_restart");
      expectStrobe(1'b1, 8'h7F, 8006);
      applySteps(1'b1, 1, 2400, 10, 3);
      expectStrobe(1'b1, 8'h03, 16006);
      applySteps(1'b1, 1, 12, 8010, 3);
      expectStrobe(1'b1, EXP_P5, 24006);
      applySteps(1'b1, 1, 20, 16010, 3);
      expectStrobe(1'b1, EXP_P40, 32006);
      applySteps(1'b1, 1, 160, 24010, 3);
      expectStrobe(1'b1, EXP_M5, 40006);
      applySteps(1'b1, -1, 20, 32010, 3);
      waitCyc(40020);

      checkOutput("main_missing_strobes", main_q.size(), 0);
      checkOutput("sat_missing_strobes", sat_q.size(), 0);

      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
